toggle_cover_sampler: RTL
=========================

# toggle_cover_sampler

Per-bit toggle detector that drives the `valid` vector of the toggle-coverage reporter. It samples a watched signal vector every cycle and tracks rising and falling edges per bit. When a bit completes a full toggle (0→1→0 or 1→0→1), it emits a one-cycle pulse on that bit's `valid` lane. It also keeps a saturating count of all reported toggles, so coverage progress is visible in simulation and synthesis.

## Interface
- `WIDTH`, 4: number of watched bits and `valid` lanes.
- `CNT_W`, 16: width of the total-toggle counter.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: sampling enable. When low, tracking is frozen.
- `clear` in 1: synchronous restart of all tracking state and the counter.
- `sig` in WIDTH: watched signal vector, sampled on every rising edge of `clock`.
- `valid` out WIDTH: registered one-cycle toggle-completion pulses, one per bit. Consumed directly by the coverage reporter.
- `toggle_count` out CNT_W: saturating total of `valid` pulses issued.

## Operation
- Internal registers:
  - `prev[WIDTH]`: last sampled value of `sig`.
  - `armed`: 1-bit flag, set once `prev` holds a valid sample.
  - Per-bit state, one of WAIT, HALF_R, HALF_F, DONE.
- Edge detection happens only when `armed`=1 and `enable`=1:
  - rise[i] = `sig[i]` & ~`prev[i]`
  - fall[i] = ~`sig[i]` & `prev[i]`
- Arming:
  - When `armed`=0 and `enable`=1, load `prev`←`sig` and set `armed`=1. No edges are evaluated that cycle.
  - When `armed`=1 and `enable`=1, update `prev`←`sig` every cycle.
- Per-bit transitions (edges are evaluated only when the bit is armed):
  - WAIT + rise → HALF_R.
  - WAIT + fall → HALF_F.
  - HALF_R + fall → completion.
  - HALF_F + rise → completion.
  - Completion → WAIT, or → DONE when `TOGGLE_COVER_ONCE_EN` is defined. DONE is held until `clear` or `reset`.
  - No edge → stay in the current state.
- A completion on bit i sets `valid[i]`=1 for exactly the next cycle. Multiple bits may complete in the same cycle.
- `toggle_count`:
  - Adds popcount(completions) each cycle.
  - Saturates at 2^CNT_W−1 and never wraps. If an addition would exceed the maximum, the result clamps to the maximum.
- `enable`=0:
  - `valid`=0.
  - Per-bit states and `toggle_count` are held.
  - `armed` is cleared, so the first enabled cycle afterwards re-loads `prev` without detecting edges. Half-toggles recorded before the disable survive.
- `clear`=1:
  - All bit states → WAIT.
  - `toggle_count` → 0.
  - `armed` → 0.
  - `valid` → 0 next cycle.
  - `clear` has priority over `enable` and over any completion in the same cycle.

## Timing
- Reset values (asynchronous): `valid`=0, `toggle_count`=0, `prev`=0, `armed`=0, all bit states WAIT.
- First enabled edge after reset deassertion only arms the block. The earliest edge detection is on the second enabled edge.
- Latency:
  - The completing edge of `sig` is sampled at clock edge k.
  - `valid[i]` is high from edge k+1 until edge k+2.
  - `toggle_count` reflects that completion from edge k+1.
- A `sig[i]` that toggles every cycle after arming completes every second cycle, so `valid[i]` pulses with a period of 2.
- `valid` never stays high for two consecutive cycles on the same bit.
- Reset asserted mid-toggle discards half-toggles immediately, without waiting for a clock edge.

## Configuration
- `TOGGLE_COVER_ONCE_EN`
  - Defined: each bit reports at most one completion between resets or clears, via the sticky DONE state. `toggle_count` is then bounded by WIDTH.
  - Undefined: DONE is unreachable and every full toggle is reported.

## Test plan
- Arming: reset, then `enable`=1 with `sig`=4'b0001 held → `valid`=0 for all cycles and `toggle_count`=0.
- Full toggle: bit0 sequence 0,1,0, one value per cycle after arming → a single `valid`=4'b0001 pulse one cycle after the falling sample, and `toggle_count`=1. With `TOGGLE_COVER_ONCE_EN` defined, repeating the sequence gives no further pulse and the count stays 1.
- Simultaneous bits: all bits toggle every cycle for 8 cycles after arming:
  - Without the macro: `valid`=4'hF on alternating cycles, and `toggle_count`=16 after 4 completions.
  - With the macro: one 4'hF pulse, then the count stays 4.
- Enable gap: bit2 rises, then `enable`=0 for 3 cycles while bit2 falls, then `enable`=1 with `sig` unchanged → no pulse (the fall is absorbed by re-arming) and bit2 stays in HALF_R. A subsequent rise then fall → pulse.
- Clear priority: assert `clear` in the same cycle as a completing edge → no `valid` pulse, `toggle_count`=0, re-arm on the next enabled cycle.
- Saturation: CNT_W=3 with continuous toggling of all bits → `toggle_count` stops at 7 and never wraps. Assert `reset` mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/toggle_cover_sampler.sv
// toggle_cover_sampler
//
// Per-bit toggle detector that drives the valid vector of the toggle-coverage
// reporter. Each watched bit is tracked by a small FSM. A full toggle
// (0->1->0 or 1->0->1) produces a one-cycle pulse on that bit's valid lane.
// A saturating counter totals every pulse issued.
//
// Build option:
//   TOGGLE_COVER_ONCE_EN - when defined, a completed bit parks in a sticky
//                          DONE state until clear/reset, so each bit reports
//                          at most once. When undefined, a completed bit
//                          returns to WAIT and every full toggle is reported.
//
// Ports:
//   clock        in            rising-edge clock
//   reset        in            asynchronous active-high reset
//   enable       in            sampling enable; low freezes tracking and disarms
//   clear        in            synchronous restart of states, counter and arming
//   sig          in  [WIDTH]   watched vector, sampled every rising edge
//   valid        out [WIDTH]   registered one-cycle completion pulses
//   toggle_count out [CNT_W]   saturating total of valid pulses
//   bit_state    out [2*WIDTH] per-bit FSM state, bit i at [2i+1:2i]
//                              (0=WAIT 1=HALF_R 2=HALF_F 3=DONE)
//
// Handshake: valid is a fire-and-forget pulse with no ready. A lane is high
// for exactly one cycle after the clock edge that sampled the completing
// value of sig; toggle_count already includes that completion in the same
// cycle.

module toggle_cover_sampler #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [WIDTH-1:0]   sig,
  output logic [WIDTH-1:0]   valid,
  output logic [CNT_W-1:0]   toggle_count,
  output logic [2*WIDTH-1:0] bit_state
);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_HALF_R = 2'd1;
  localparam logic [1:0] ST_HALF_F = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

`ifdef TOGGLE_COVER_ONCE_EN
  localparam logic [1:0] ST_AFTER_COMPLETE = ST_DONE;
`else
  localparam logic [1:0] ST_AFTER_COMPLETE = ST_WAIT;
`endif

  localparam int PC_W = $clog2(WIDTH + 1);

  // Saturation compare is done one bit wider than the counter so the sum of
  // the current count and this cycle's popcount cannot overflow silently.
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [WIDTH-1:0]      prev;
  logic                  armed;
  logic [WIDTH-1:0][1:0] state_q;
  logic [WIDTH-1:0][1:0] state_nxt;
  logic [WIDTH-1:0]      rise;
  logic [WIDTH-1:0]      fall;
  logic [WIDTH-1:0]      comp;
  logic                  detect;
  logic [PC_W-1:0]       pc;
  logic [CNT_W:0]        sum;
  logic [CNT_W-1:0]      cnt_nxt;

  assign bit_state = state_q;

  // Edges are only meaningful once prev holds a sample taken while enabled.
  assign detect = armed & enable;
  assign rise   = sig & ~prev;
  assign fall   = ~sig & prev;

  always_comb begin
    state_nxt = state_q;
    comp      = '0;
    pc        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (detect) begin
        case (state_q[i])
          ST_WAIT: begin
            if (rise[i])      state_nxt[i] = ST_HALF_R;
            else if (fall[i]) state_nxt[i] = ST_HALF_F;
          end
          ST_HALF_R: begin
            if (fall[i]) begin
              comp[i]      = 1'b1;
              state_nxt[i] = ST_AFTER_COMPLETE;
            end
          end
          ST_HALF_F: begin
            if (rise[i]) begin
              comp[i]      = 1'b1;
              state_nxt[i] = ST_AFTER_COMPLETE;
            end
          end
          ST_DONE: state_nxt[i] = ST_DONE;
        endcase
      end
      pc = pc + PC_W'(comp[i]);
    end
    sum     = {1'b0, toggle_count} + (CNT_W + 1)'(pc);
    cnt_nxt = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid        <= '0;
      toggle_count <= '0;
      prev         <= '0;
      armed        <= 1'b0;
      state_q      <= '0;
    end else if (clear) begin
      // Clear wins over enable and over a completion in the same cycle.
      valid        <= '0;
      toggle_count <= '0;
      armed        <= 1'b0;
      state_q      <= '0;
    end else if (!enable) begin
      // Half-toggles survive a disable; disarming makes the next enabled
      // cycle reload prev so edges that happened while frozen are ignored.
      valid <= '0;
      armed <= 1'b0;
    end else begin
      // When not yet armed, detect is low: comp is zero and state/count hold,
      // so this single branch also covers the arming cycle.
      valid        <= comp;
      state_q      <= state_nxt;
      toggle_count <= cnt_nxt;
      prev         <= sig;
      armed        <= 1'b1;
    end
  end

endmodule
